mpu_seq: RTL and testbench
==========================

Name: mpu_seq

Overview:
Parametrised, sequential successor to the combinational multiply unit. It accepts a packed instruction {op, a, b}, runs a shift-add multiply over W cycles, and returns a W-bit result. Beyond the combinational unit it adds:
- a high/low product select,
- a multiply-accumulate register with clear,
- valid/ready handshakes on both sides.

It sits between the instruction issue stage and the writeback register.

Parameters:
W, 9, operand and result width in bits; instruction width is 2*W+2.
ACC_W, 2*W, accumulator and full-product width.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
instr  input  2*W+2  {op[1:0], a[W-1:0], b[W-1:0]}; a = instr[2W-1:W], b = instr[W-1:0].
in_valid  input  1  instr is valid this cycle.
in_ready  output  1  block can accept instr; high only in IDLE.
out  output  W  result, valid while out_valid is high.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
busy  output  1  high in BUSY.

Behaviour:
- Reset (rst_n low at a clock edge, in any state, including mid-multiply):
  - state goes to IDLE; out, out_valid, busy, acc and the internal product/counter all go to 0; in_ready goes to 1;
  - any in-flight operation is discarded without a result.
- Opcodes:
  - 00 MULL: out = product[W-1:0].
  - 01 MULH: out = product[2W-1:W].
  - 10 MAC: acc = acc + product, modulo 2^ACC_W (wraps silently); out = new acc[W-1:0].
  - 11 CLR: acc = 0; out = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1; in_valid high at an edge accepts the instruction (handshake).
  - op 11 goes directly to DONE on that edge.
  - Other ops latch a, b and op, clear the partial product, load the counter with W, and go to BUSY.
- BUSY:
  - each cycle, if the multiplier LSB = 1, add the shifted multiplicand to the partial product; shift; decrement the counter.
  - On the edge where the counter reaches 0, the result (and acc for MAC) is registered, out_valid is set, and state goes to DONE.
- Latency: instruction accepted at edge k gives out_valid high after edge k+W (MUL/MAC) or after edge k (CLR).
- DONE:
  - out and out_valid are held stable until out_ready is high at an edge; then out_valid drops and state goes to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept. Back-to-back throughput is one op per W+2 cycles.
- Input handling:
  - in_valid in BUSY or DONE is ignored and not queued; the upstream stage must hold it.
  - out_ready without out_valid has no effect.
- Operand edge cases: a = 0 or b = 0 gives 0 with the same latency; there is no early termination.
- acc changes only on MAC/CLR completion or reset.

Optional Feature:
Macro MPU_SIGNED_EN.
- Defined: a, b and out are two's complement.
  - Operands are converted to magnitude before BUSY, and the product is negated at completion if the signs differ.
  - The most-negative operand (-2^(W-1)) is handled correctly; magnitude is held in W bits unsigned.
  - MULH returns the signed high half.
  - MAC adds the sign-extended ACC_W product.
- Not defined: all operands are unsigned; latency is identical in both builds.

Decomposition:
- Package mpu_pkg holds:
  - opcode localparams OP_MULL, OP_MULH, OP_MAC, OP_CLR;
  - state encoding S_IDLE, S_BUSY, S_DONE;
  - the instruction field slice helper constants.
- One sub-module is natural: mpu_shift_add_core, holding the counter, multiplicand/multiplier shift registers and partial product, with start/done strobes.
- FSM, acc, opcode select and handshakes stay in mpu_seq.

Test Plan:
1. Reset, then MULL with instr = 20'b00_000000011_100000001 (a = 3, b = 257): out_valid rises 9 cycles after accept, out = 9'h103; MULH with the same operands gives out = 9'h001.
2. Hold out_ready = 0 for 5 cycles in DONE: out and out_valid stay stable and in_ready stays 0. Assert out_ready: IDLE on the next edge, in_ready = 1.
3. CLR, then MAC(3, 257) twice: first out = 9'h103, second out = 9'h006 (acc = 0x606); CLR completes in 1 cycle with out = 0.
4. Assert rst_n = 0 for one cycle at BUSY cycle 4: out_valid never rises, acc = 0, in_ready = 1 after the edge; a following MULL(5, 7) gives 35.
5. MULL(511, 511): product 0x3FC01, so MULL = 9'h001 and MULH = 9'h1FE; MAC repeated 4 times wraps acc modulo 2^18.
6. With MPU_SIGNED_EN, MULL/MULH(3, 9'b100000001 = -255): low = 9'h103, high = 9'h1FE (product -765 = 18'h3FD03); MULH(-256, -256) = 9'h080.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared opcodes, FSM state encoding and instruction field helpers for the
// sequential multiply unit.
package mpu_pkg;

  localparam logic [1:0] OP_MULL = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_MAC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int OP_W = 2;

  // Instruction layout is {op, a, b}: op sits above both W-bit operands.
  function automatic int op_lsb(input int w);
    return 2 * w;
  endfunction

  function automatic int a_lsb(input int w);
    return w;
  endfunction

endpackage

// File: rtl/mpu_shift_add_core.sv
// Unsigned W-cycle shift-add multiplier: start loads the operands, done strobes
// during the cycle whose edge retires the last step, with product then valid.
module mpu_shift_add_core #(
  parameter int W = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int CNT_W = $clog2(W + 1);

  logic [2*W-1:0]   mcand_r;
  logic [W-1:0]     mplier_r;
  logic [2*W-1:0]   prod_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2*W-1:0]   addend_s;
  logic [2*W-1:0]   prod_nxt_s;

  // Partial-product step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    addend_s = {(2*W){1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {(2*W){1'b0}};
    end
    prod_nxt_s = prod_r + addend_s;
  end

  // The final sum is exposed combinationally so the parent can register it on the done edge.
  assign product = prod_nxt_s;
  assign done    = (cnt_r == CNT_W'(1));

  // Operand load, per-cycle shift and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r  <= {(2*W){1'b0}};
      mplier_r <= {W{1'b0}};
      prod_r   <= {(2*W){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (start) begin
      mcand_r  <= {{W{1'b0}}, multiplicand};
      mplier_r <= multiplier;
      prod_r   <= {(2*W){1'b0}};
      cnt_r    <= CNT_W'(W);
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      prod_r   <= prod_nxt_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mpu_seq.sv
// Sequential multiply / multiply-accumulate unit with valid/ready handshakes.
// Define MPU_SIGNED_EN to treat a, b and out as two's complement.
module mpu_seq
  import mpu_pkg::*;
#(
  parameter int W     = 9,
  parameter int ACC_W = 2 * W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*W+1:0] instr,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  localparam int OP_LSB = op_lsb(W);
  localparam int A_LSB  = a_lsb(W);

  state_t             state_r, state_nxt_s;
  logic [1:0]         op_r;
  logic [ACC_W-1:0]   acc_r;
  logic [W-1:0]       out_r;
  logic               out_valid_r, in_ready_r, busy_r;
  logic [1:0]         op_in_s;
  logic [W-1:0]       a_s, b_s, a_mag_s, b_mag_s;
  logic               core_start_s, core_done_s;
  logic [2*W-1:0]     core_prod_s, full_s;
  logic [ACC_W-1:0]   acc_sum_s;
  logic [W-1:0]       result_s;
`ifdef MPU_SIGNED_EN
  logic               neg_r;
`endif

  assign op_in_s = instr[OP_LSB +: OP_W];
  assign a_s     = instr[A_LSB +: W];
  assign b_s     = instr[W-1:0];

  mpu_shift_add_core #(.W(W)) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (core_start_s),
    .multiplicand (a_mag_s),
    .multiplier   (b_mag_s),
    .product      (core_prod_s),
    .done         (core_done_s)
  );

  // Operand magnitudes into the core and sign restoration of the finished product.
  always_comb begin
`ifdef MPU_SIGNED_EN
    if (a_s[W-1]) a_mag_s = ~a_s + {{(W-1){1'b0}}, 1'b1};
    else          a_mag_s = a_s;
    if (b_s[W-1]) b_mag_s = ~b_s + {{(W-1){1'b0}}, 1'b1};
    else          b_mag_s = b_s;
    if (neg_r) full_s = ~core_prod_s + {{(2*W-1){1'b0}}, 1'b1};
    else       full_s = core_prod_s;
    acc_sum_s = acc_r + ACC_W'($signed(full_s));
`else
    a_mag_s   = a_s;
    b_mag_s   = b_s;
    full_s    = core_prod_s;
    acc_sum_s = acc_r + ACC_W'(full_s);
`endif
  end

  // Result select by latched opcode.
  always_comb begin
    result_s = {W{1'b0}};
    case (op_r)
      OP_MULL: result_s = full_s[W-1:0];
      OP_MULH: result_s = full_s[2*W-1:W];
      OP_MAC:  result_s = acc_sum_s[W-1:0];
      default: result_s = {W{1'b0}};
    endcase
  end

  // Next-state logic; CLR bypasses the multiplier entirely.
  always_comb begin
    state_nxt_s  = state_r;
    core_start_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          if (op_in_s == OP_CLR) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s  = S_BUSY;
            core_start_s = 1'b1;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (core_done_s) state_nxt_s = S_DONE;
        else             state_nxt_s = S_BUSY;
      end
      S_DONE: begin
        if (out_ready) state_nxt_s = S_IDLE;
        else           state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, handshake flags, accumulator and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      op_r        <= OP_MULL;
      acc_r       <= {ACC_W{1'b0}};
      out_r       <= {W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
`ifdef MPU_SIGNED_EN
      neg_r       <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == S_IDLE);
      busy_r     <= (state_nxt_s == S_BUSY);
      if (core_start_s) begin
        op_r  <= op_in_s;
`ifdef MPU_SIGNED_EN
        neg_r <= a_s[W-1] ^ b_s[W-1];
`endif
      end
      if (state_r == S_IDLE && in_valid && op_in_s == OP_CLR) begin
        acc_r       <= {ACC_W{1'b0}};
        out_r       <= {W{1'b0}};
        out_valid_r <= 1'b1;
      end else if (state_r == S_BUSY && core_done_s) begin
        out_r       <= result_s;
        out_valid_r <= 1'b1;
        if (op_r == OP_MAC) acc_r <= acc_sum_s;
      end else if (state_r == S_DONE && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out       = out_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mpu_seq.sv
// Self-checking bench for mpu_seq: directed plan cases plus randomized ops
// checked against an arithmetic reference model.
module tb_mpu_seq;
  import mpu_pkg::*;

  localparam int W     = 9;
  localparam int ACC_W = 2 * W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2*W+1:0] instr = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           busy;

  int errors = 0;
  int checks = 0;
  logic [ACC_W-1:0] model_acc = '0;

  mpu_seq #(.W(W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: full product from plain integer arithmetic, then opcode rules.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] exp);
    int sa, sb;
    logic [ACC_W-1:0] p;
`ifdef MPU_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    p = ACC_W'(sa * sb);
    case (op)
      2'b00: exp = p[W-1:0];
      2'b01: exp = p[2*W-1:W];
      2'b10: begin model_acc = model_acc + p; exp = model_acc[W-1:0]; end
      default: begin model_acc = '0; exp = '0; end
    endcase
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, output logic [W-1:0] res);
    logic [W-1:0] exp;
    int n, exp_lat;
    model(op, a, b, exp);
    exp_lat = (op == OP_CLR) ? 0 : W;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL pre_accept_in_ready: got %b want 1", in_ready);
    instr = {op, a, b};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_flags: busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL latency op=%0d: got %0d want %0d", op, n, exp_lat);
    end
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h: got %h want %h", op, a, b, out, exp);
    end
    res = out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      instr = {OP_MULL, 9'd1, 9'd1};
      @(posedge clk); #1;
      checks++;
      if (out !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_done: out=%h valid=%b in_ready=%b want %h/1/0", out, out_valid, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_acc = '0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b valid=%b busy=%b out=%h want 1/0/0/0",
               in_ready, out_valid, busy, out);
    end
  endtask

  task automatic test_mul_basic();
    logic [W-1:0] r;
    do_op(OP_MULL, 9'd3, 9'd257, 0, r);
`ifndef MPU_SIGNED_EN
    checks++;
    if (r !== 9'h103) begin errors++; $display("FAIL mull_3_257: got %h want 103", r); end
`endif
    do_op(OP_MULH, 9'd3, 9'd257, 0, r);
`ifndef MPU_SIGNED_EN
    checks++;
    if (r !== 9'h001) begin errors++; $display("FAIL mulh_3_257: got %h want 001", r); end
`endif
    do_op(OP_MULL, 9'd0, 9'd345, 0, r);
    do_op(OP_MULH, 9'd77, 9'd0, 0, r);
  endtask

  task automatic test_hold();
    logic [W-1:0] r;
    do_op(OP_MULL, 9'd3, 9'd257, 5, r);
  endtask

  task automatic test_mac();
    logic [W-1:0] r;
    do_op(OP_CLR, 9'd0, 9'd0, 0, r);
    do_op(OP_MAC, 9'd3, 9'd257, 0, r);
`ifndef MPU_SIGNED_EN
    checks++;
    if (r !== 9'h103) begin errors++; $display("FAIL mac1: got %h want 103", r); end
`endif
    do_op(OP_MAC, 9'd3, 9'd257, 0, r);
`ifndef MPU_SIGNED_EN
    checks++;
    if (r !== 9'h006) begin errors++; $display("FAIL mac2: got %h want 006", r); end
`endif
    do_op(OP_CLR, 9'd5, 9'd6, 0, r);
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] r;
    int seen;
    do_op(OP_MAC, 9'd3, 9'd257, 0, r);
    instr = {OP_MAC, 9'd5, 9'd7};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_acc = '0;
    repeat (W) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: valid_seen=%0d in_ready=%b busy=%b want 0/1/0", seen, in_ready, busy);
    end
    do_op(OP_MULL, 9'd5, 9'd7, 0, r);
    checks++;
    if (r !== 9'd35) begin errors++; $display("FAIL mull_5_7: got %0d want 35", r); end
    do_op(OP_MAC, 9'd1, 9'd1, 0, r);
    checks++;
    if (r !== 9'd1) begin errors++; $display("FAIL acc_after_reset: got %h want 001", r); end
  endtask

  task automatic test_max();
    logic [W-1:0] r;
    do_op(OP_MULL, 9'd511, 9'd511, 0, r);
`ifndef MPU_SIGNED_EN
    checks++;
    if (r !== 9'h001) begin errors++; $display("FAIL mull_max: got %h want 001", r); end
`endif
    do_op(OP_MULH, 9'd511, 9'd511, 0, r);
`ifndef MPU_SIGNED_EN
    checks++;
    if (r !== 9'h1FE) begin errors++; $display("FAIL mulh_max: got %h want 1fe", r); end
`endif
    do_op(OP_CLR, 9'd0, 9'd0, 0, r);
    repeat (4) do_op(OP_MAC, 9'd511, 9'd511, 0, r);
  endtask

`ifdef MPU_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] r;
    do_op(OP_MULL, 9'd3, 9'b100000001, 0, r);
    checks++;
    if (r !== 9'h103) begin errors++; $display("FAIL smull: got %h want 103", r); end
    do_op(OP_MULH, 9'd3, 9'b100000001, 0, r);
    checks++;
    if (r !== 9'h1FE) begin errors++; $display("FAIL smulh: got %h want 1fe", r); end
    do_op(OP_MULH, 9'h100, 9'h100, 0, r);
    checks++;
    if (r !== 9'h080) begin errors++; $display("FAIL smulh_minneg: got %h want 080", r); end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] r, a, b;
    logic [1:0] op;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 5) == 0) a = '0;
      if ($urandom_range(0, 5) == 0) b = '0;
      do_op(op, a, b, 0, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    int last, outs;
    instr = {OP_MAC, 9'd17, 9'd29};
    in_valid = 1'b1;
    out_ready = 1'b1;
    last = -1;
    outs = 0;
    for (int c = 1; c <= 4 * (W + 2); c++) begin
      @(posedge clk); #1;
      if (c == 4 * (W + 2)) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        model(OP_MAC, 9'd17, 9'd29, exp);
        checks++;
        if (out !== exp) begin errors++; $display("FAIL b2b_value: got %h want %h", out, exp); end
        if (last >= 0) begin
          checks++;
          if (c - last != W + 2) begin
            errors++;
            $display("FAIL b2b_interval: got %0d want %0d", c - last, W + 2);
          end
        end
        last = c;
        outs++;
      end
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (outs != 4 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: got %0d in_ready=%b want 4/1", outs, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_hold();
    test_mac();
    test_reset_midop();
    test_max();
`ifdef MPU_SIGNED_EN
    test_signed();
`endif
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
